// File: rtl/dmem_arbiter_pkg.sv
// Shared defines for the data-memory arbiter: default widths, func3 size codes,
// FSM state encoding and grant encoding.
package dmem_arbiter_pkg;

    localparam int DEF_ADDR_WIDTH  = 32;
    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_FUNC3_WIDTH = 3;

    localparam logic [DEF_FUNC3_WIDTH-1:0] F3_B  = 3'd0;
    localparam logic [DEF_FUNC3_WIDTH-1:0] F3_H  = 3'd1;
    localparam logic [DEF_FUNC3_WIDTH-1:0] F3_W  = 3'd2;
    localparam logic [DEF_FUNC3_WIDTH-1:0] F3_BU = 3'd4;
    localparam logic [DEF_FUNC3_WIDTH-1:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic GRANT_CPU = 1'b0;
    localparam logic GRANT_DBG = 1'b1;

endpackage

// File: rtl/dmem_arbiter_align.sv
// Combinational misalignment detector for CPU loads/stores; reserved func3
// codes are treated as misaligned so they can never reach memory as a write.
module dmem_align_check
    import dmem_arbiter_pkg::*;
#(
    parameter int Func3Width = DEF_FUNC3_WIDTH
) (
    input  logic [Func3Width-1:0] func3,
    input  logic [1:0]            addr,
    output logic                  misaligned
);

    always_comb begin
        misaligned = 1'b0;
        case (func3)
            F3_B, F3_BU: misaligned = 1'b0;
            F3_H, F3_HU: misaligned = (addr == 2'b11);
            F3_W:        misaligned = (addr != 2'b00);
            default:     misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data memory between the CPU MEM stage and a
// word-only debug/loader port; each access takes IDLE -> ACCESS -> RESP.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int AddrWidth  = DEF_ADDR_WIDTH,
    parameter int DataWidth  = DEF_DATA_WIDTH,
    parameter int Func3Width = DEF_FUNC3_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [Func3Width-1:0] cpu_func3,
    input  logic [AddrWidth-1:0]  cpu_addr,
    input  logic [DataWidth-1:0]  cpu_wdata,
    output logic [DataWidth-1:0]  cpu_rdata,
    output logic                  cpu_ack,
    output logic                  cpu_err,
    output logic                  cpu_stall,
    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [AddrWidth-1:0]  dbg_addr,
    input  logic [DataWidth-1:0]  dbg_wdata,
    output logic [DataWidth-1:0]  dbg_rdata,
    output logic                  dbg_ack,
    output logic                  mem_we,
    output logic [Func3Width-1:0] mem_func3,
    output logic [AddrWidth-1:0]  mem_addr,
    output logic [DataWidth-1:0]  mem_wdata,
    input  logic [DataWidth-1:0]  mem_rdata
);

    state_t state, state_nxt;
    logic   grant, grant_nxt, last_grant;
    logic   err_q;
    logic   misaligned;
    logic   access, resp;
    logic   unused_dbg_lsb;

    assign unused_dbg_lsb = &{1'b0, dbg_addr[1:0]};

    dmem_align_check #(.Func3Width(Func3Width)) u_align (
        .func3      (cpu_func3),
        .addr       (cpu_addr[1:0]),
        .misaligned (misaligned)
    );

    assign access = (state == ST_ACCESS);
    assign resp   = (state == ST_RESP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            grant      <= GRANT_CPU;
            last_grant <= GRANT_DBG;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            if (resp) begin
                last_grant <= grant;
            end
        end
    end

    // Memory is driven only while ACCESS is live; rst gates mem_we directly so a
    // reset landing mid-write drops the strobe before the closing edge.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        mem_we    = 1'b0;
        mem_func3 = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            ST_IDLE: begin
                if (cpu_req && dbg_req) begin
                    grant_nxt = ~last_grant;
                    state_nxt = ST_ACCESS;
                end else if (cpu_req) begin
                    grant_nxt = GRANT_CPU;
                    state_nxt = ST_ACCESS;
                end else if (dbg_req) begin
                    grant_nxt = GRANT_DBG;
                    state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                state_nxt = ST_RESP;
                if (!rst) begin
                    if (grant == GRANT_DBG) begin
                        mem_we    = dbg_we;
                        mem_func3 = F3_W;
                        mem_addr  = {dbg_addr[AddrWidth-1:2], 2'b00};
                        mem_wdata = dbg_wdata;
                    end else begin
                        mem_we    = cpu_we & ~misaligned;
                        mem_func3 = cpu_func3;
                        mem_addr  = cpu_addr;
                        mem_wdata = cpu_wdata;
                    end
                end
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_rdata <= '0;
            dbg_rdata <= '0;
            err_q     <= 1'b0;
        end else if (access) begin
            if (grant == GRANT_DBG) begin
                dbg_rdata <= mem_rdata;
            end else begin
                cpu_rdata <= misaligned ? '0 : mem_rdata;
                err_q     <= misaligned;
            end
        end
    end

    assign cpu_ack   = resp && (grant == GRANT_CPU);
    assign dbg_ack   = resp && (grant == GRANT_DBG);
    assign cpu_err   = cpu_ack && err_q;
    assign cpu_stall = cpu_req && !cpu_ack;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte-array reference model of arbitration and memory
// semantics, per-cycle output compare, directed scenarios and random traffic.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [2:0]  cpu_func3;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_ack, cpu_err, cpu_stall;
    logic        dbg_req, dbg_we;
    logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic        dbg_ack;
    logic        mem_we;
    logic [2:0]  mem_func3;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int total = 0;
    int bad   = 0;
    int we_cycles = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_func3(cpu_func3),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
        .mem_we(mem_we), .mem_func3(mem_func3), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- data memory device (word array, little-endian lanes)
    logic [31:0] dev_mem [0:63];
    logic [31:0] dev_word, dev_shift;

    always_comb begin
        dev_word  = dev_mem[mem_addr[7:2]];
        dev_shift = dev_word >> {mem_addr[1:0], 3'b000};
        mem_rdata = dev_word;
        case (mem_func3)
            3'd0: mem_rdata = {{24{dev_shift[7]}}, dev_shift[7:0]};
            3'd1: mem_rdata = {{16{dev_shift[15]}}, dev_shift[15:0]};
            3'd4: mem_rdata = {24'd0, dev_shift[7:0]};
            3'd5: mem_rdata = {16'd0, dev_shift[15:0]};
            default: mem_rdata = dev_word;
        endcase
    end

    always @(posedge clk) begin
        if (mem_we) begin
            case (mem_func3)
                3'd0, 3'd4: dev_mem[mem_addr[7:2]][{mem_addr[1:0], 3'b000} +: 8]  <= mem_wdata[7:0];
                3'd1, 3'd5: dev_mem[mem_addr[7:2]][{mem_addr[1:0], 3'b000} +: 16] <= mem_wdata[15:0];
                default:    dev_mem[mem_addr[7:2]] <= mem_wdata;
            endcase
        end
    end

    always @(negedge clk) begin
        if (mem_we) we_cycles <= we_cycles + 1;
    end

    // ---------------- reference model (transaction level, byte memory)
    logic [7:0]  ref_mem [0:255];
    int          m_age;       // -1 idle, 0 access cycle, 1 response cycle
    bit          m_owner;     // 0 cpu, 1 dbg
    bit          m_prev;
    bit          m_mis;
    logic [31:0] m_cpu_rdata, m_dbg_rdata;

    initial begin
        for (int i = 0; i < 64; i++) dev_mem[i] <= 32'd0;
        for (int i = 0; i < 256; i++) ref_mem[i] <= 8'd0;
    end

    function automatic bit mis_f(input logic [2:0] f, input logic [1:0] a);
        case (f)
            3'd0, 3'd4: return 1'b0;
            3'd1, 3'd5: return a == 2'd3;
            3'd2:       return a != 2'd0;
            default:    return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f, input logic [7:0] a);
        logic [7:0] b0, b1, b2, b3;
        b0 = ref_mem[a];
        b1 = ref_mem[a + 8'd1];
        b2 = ref_mem[a + 8'd2];
        b3 = ref_mem[a + 8'd3];
        case (f)
            3'd0: return {{24{b0[7]}}, b0};
            3'd4: return {24'd0, b0};
            3'd1: return {{16{b1[7]}}, b1, b0};
            3'd5: return {16'd0, b1, b0};
            3'd2: return {b3, b2, b1, b0};
            default: return 32'd0;
        endcase
    endfunction

    task automatic ref_store(input logic [2:0] f, input logic [7:0] a, input logic [31:0] d);
        int n;
        n = (f == 3'd2) ? 4 : ((f == 3'd1 || f == 3'd5) ? 2 : 1);
        for (int k = 0; k < n; k++) ref_mem[a + 8'(k)] <= d[8*k +: 8];
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_age       <= -1;
            m_owner     <= 1'b0;
            m_prev      <= 1'b1;
            m_mis       <= 1'b0;
            m_cpu_rdata <= 32'd0;
            m_dbg_rdata <= 32'd0;
        end else if (m_age < 0) begin
            if (cpu_req || dbg_req) begin
                m_owner <= (cpu_req && dbg_req) ? !m_prev : dbg_req;
                m_age   <= 0;
            end
        end else if (m_age == 0) begin
            m_age <= 1;
            if (m_owner) begin
                m_dbg_rdata <= ref_load(3'd2, dbg_addr[7:0] & 8'hFC);
                if (dbg_we) ref_store(3'd2, dbg_addr[7:0] & 8'hFC, dbg_wdata);
            end else if (mis_f(cpu_func3, cpu_addr[1:0])) begin
                m_mis       <= 1'b1;
                m_cpu_rdata <= 32'd0;
            end else begin
                m_mis       <= 1'b0;
                m_cpu_rdata <= ref_load(cpu_func3, cpu_addr[7:0]);
                if (cpu_we) ref_store(cpu_func3, cpu_addr[7:0], cpu_wdata);
            end
        end else begin
            m_prev <= m_owner;
            m_age  <= -1;
        end
    end

    logic        e_cpu_ack, e_dbg_ack, e_cpu_err, e_stall, e_we;
    logic [2:0]  e_f3;
    logic [31:0] e_addr, e_wd;

    always_comb begin
        e_cpu_ack = (m_age == 1) && !m_owner;
        e_dbg_ack = (m_age == 1) && m_owner;
        e_cpu_err = e_cpu_ack && m_mis;
        e_stall   = cpu_req && !e_cpu_ack;
        e_we   = 1'b0;
        e_f3   = 3'd0;
        e_addr = 32'd0;
        e_wd   = 32'd0;
        if (m_age == 0 && !rst) begin
            if (m_owner) begin
                e_we   = dbg_we;
                e_f3   = 3'd2;
                e_addr = {dbg_addr[31:2], 2'b00};
                e_wd   = dbg_wdata;
            end else begin
                e_we   = cpu_we && !mis_f(cpu_func3, cpu_addr[1:0]);
                e_f3   = cpu_func3;
                e_addr = cpu_addr;
                e_wd   = cpu_wdata;
            end
        end
    end

    always @(negedge clk) begin
        chk("cpu_ack",   32'(cpu_ack),   32'(e_cpu_ack));
        chk("dbg_ack",   32'(dbg_ack),   32'(e_dbg_ack));
        chk("cpu_err",   32'(cpu_err),   32'(e_cpu_err));
        chk("cpu_stall", 32'(cpu_stall), 32'(e_stall));
        chk("cpu_rdata", cpu_rdata, m_cpu_rdata);
        chk("dbg_rdata", dbg_rdata, m_dbg_rdata);
        chk("mem_we",    32'(mem_we),    32'(e_we));
        chk("mem_func3", 32'(mem_func3), 32'(e_f3));
        chk("mem_addr",  mem_addr,  e_addr);
        chk("mem_wdata", mem_wdata, e_wd);
    end

    // ---------------- stimulus helpers
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic cpu_do(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] rd, output logic err,
                          output int lat);
        cpu_we = we; cpu_func3 = f3; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1;
        lat = -1; rd = 32'd0; err = 1'b0;
        for (int n = 1; n <= 20 && lat < 0; n++) begin
            cyc();
            if (cpu_ack) begin lat = n; rd = cpu_rdata; err = cpu_err; end
        end
        cpu_req = 1'b0;
        cyc();
    endtask

    task automatic dbg_do(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output int lat,
                          output logic [31:0] acc_addr, output logic [2:0] acc_f3);
        dbg_we = we; dbg_addr = addr; dbg_wdata = wd; dbg_req = 1'b1;
        lat = -1; rd = 32'd0; acc_addr = 32'd0; acc_f3 = 3'd0;
        for (int n = 1; n <= 20 && lat < 0; n++) begin
            cyc();
            if (n == 1) begin acc_addr = mem_addr; acc_f3 = mem_func3; end
            if (dbg_ack) begin lat = n; rd = dbg_rdata; end
        end
        dbg_req = 1'b0;
        cyc();
    endtask

    // Both ports raise reads together; the cpu optionally issues a second read
    // right after its first ack while keeping req high.
    task automatic tie_round(input logic [31:0] ca, input logic [31:0] ca2, input logic [31:0] da,
                             input int ncpu, output int c0, output int c1, output int d0,
                             output logic [31:0] crd0, output logic [31:0] crd1,
                             output logic [31:0] drd);
        int cc;
        cpu_we = 1'b0; cpu_func3 = 3'd2; cpu_addr = ca;
        dbg_we = 1'b0; dbg_addr = da;
        cpu_req = 1'b1; dbg_req = 1'b1;
        cc = 0; c0 = -1; c1 = -1; d0 = -1; crd0 = 32'd0; crd1 = 32'd0; drd = 32'd0;
        for (int n = 1; n <= 20 && (cpu_req || dbg_req); n++) begin
            cyc();
            if (cpu_ack) begin
                if (cc == 0) begin c0 = n; crd0 = cpu_rdata; end
                else begin c1 = n; crd1 = cpu_rdata; end
                cc++;
                if (cc < ncpu) cpu_addr = ca2; else cpu_req = 1'b0;
            end
            if (dbg_ack) begin d0 = n; drd = dbg_rdata; dbg_req = 1'b0; end
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        cyc();
    endtask

    task automatic new_cpu();
        cpu_req   = 1'b1;
        cpu_we    = 1'($urandom_range(1));
        cpu_func3 = ($urandom_range(3) == 0) ? 3'($urandom_range(7)) : 3'd2;
        if ($urandom_range(2) == 0) cpu_func3 = 3'($urandom_range(1) ? 4 : 0);
        cpu_addr  = $urandom;
        if ($urandom_range(1) == 1) cpu_addr[1:0] = 2'b00;
        cpu_wdata = $urandom;
    endtask

    task automatic new_dbg();
        dbg_req   = 1'b1;
        dbg_we    = 1'($urandom_range(1));
        dbg_addr  = $urandom;
        dbg_wdata = $urandom;
    endtask

    // ---------------- main sequence
    logic [31:0] rd, acc_a, crd0, crd1, drd;
    logic [2:0]  acc_f;
    logic        err;
    int          lat, w0, c0, c1, d0, k, stall_bad;
    int          ack_n [4];
    logic [31:0] rd_n [4];

    initial begin
        rst = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_func3 = 3'd0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 32'd0; dbg_wdata = 32'd0;
        cyc(); cyc();
        chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        chk("rst_dbg_ack", 32'(dbg_ack), 32'd0);
        chk("rst_cpu_rdata", cpu_rdata, 32'd0);
        chk("rst_dbg_rdata", dbg_rdata, 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        rst = 1'b0;
        cyc();

        // store then load a word
        w0 = we_cycles;
        cpu_do(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, rd, err, lat);
        chk("sw_lat", 32'(lat), 32'd2);
        chk("sw_we_cycles", 32'(we_cycles - w0), 32'd1);
        cpu_do(1'b0, 3'd2, 32'h10, 32'd0, rd, err, lat);
        chk("lw_lat", 32'(lat), 32'd2);
        chk("lw_rdata", rd, 32'hDEADBEEF);

        // misaligned word store
        w0 = we_cycles;
        cpu_do(1'b1, 3'd2, 32'h12, 32'h12345678, rd, err, lat);
        chk("mis_we_cycles", 32'(we_cycles - w0), 32'd0);
        chk("mis_ack_lat", 32'(lat), 32'd2);
        chk("mis_err", 32'(err), 32'd1);
        chk("mis_rdata", rd, 32'd0);

        // dbg word write with unaligned address, then cpu lbu
        dbg_do(1'b1, 32'h23, 32'h000000FF, rd, lat, acc_a, acc_f);
        chk("dbg_acc_addr", acc_a, 32'h20);
        chk("dbg_acc_f3", 32'(acc_f), 32'd2);
        chk("dbg_lat", 32'(lat), 32'd2);
        cpu_do(1'b0, 3'd4, 32'h20, 32'd0, rd, err, lat);
        chk("lbu_rdata", rd, 32'h000000FF);
        cpu_do(1'b0, 3'd0, 32'h20, 32'd0, rd, err, lat);
        chk("lb_rdata", rd, 32'hFFFFFFFF);

        // preload 0x80..0x8C
        for (int i = 0; i < 4; i++) begin
            dbg_do(1'b1, 32'h80 + 32'(4 * i), 32'h11111111 * 32'(i + 1), rd, lat, acc_a, acc_f);
        end

        // simultaneous requests: cpu wins first tie, then repeated tie goes to dbg
        tie_round(32'h80, 32'h88, 32'h84, 2, c0, c1, d0, crd0, crd1, drd);
        chk("tie1_cpu_ack", 32'(c0), 32'd2);
        chk("tie1_dbg_ack", 32'(d0), 32'd5);
        chk("tie1_cpu_ack2", 32'(c1), 32'd8);
        chk("tie1_cpu_rd", crd0, 32'h11111111);
        chk("tie1_dbg_rd", drd, 32'h22222222);
        chk("tie1_cpu_rd2", crd1, 32'h33333333);
        tie_round(32'h8C, 32'h8C, 32'h80, 1, c0, c1, d0, crd0, crd1, drd);
        chk("tie2_dbg_ack", 32'(d0), 32'd2);
        chk("tie2_cpu_ack", 32'(c0), 32'd5);
        chk("tie2_cpu_rd", crd0, 32'h44444444);

        // reset during ACCESS of a cpu store
        w0 = we_cycles;
        cpu_we = 1'b1; cpu_func3 = 3'd2; cpu_addr = 32'h40; cpu_wdata = 32'hCAFEF00D; cpu_req = 1'b1;
        cyc();
        chk("abort_we_in_access", 32'(mem_we), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_we_comb", 32'(mem_we), 32'd0);
        cyc();
        chk("abort_no_ack", 32'(cpu_ack), 32'd0);
        chk("abort_we_after", 32'(mem_we), 32'd0);
        rst = 1'b0;
        lat = -1;
        for (int n = 1; n <= 20 && lat < 0; n++) begin
            cyc();
            if (cpu_ack) lat = n;
        end
        cpu_req = 1'b0;
        cyc();
        chk("abort_reserve_lat", 32'(lat), 32'd2);
        chk("abort_we_cycles", 32'(we_cycles - w0), 32'd1);
        cpu_do(1'b0, 3'd2, 32'h40, 32'd0, rd, err, lat);
        chk("abort_readback", rd, 32'hCAFEF00D);

        // four back-to-back loads with req held
        cpu_we = 1'b0; cpu_func3 = 3'd2; cpu_addr = 32'h80; cpu_req = 1'b1;
        k = 0; stall_bad = 0;
        for (int i = 0; i < 4; i++) begin ack_n[i] = -1; rd_n[i] = 32'd0; end
        for (int n = 1; n <= 16 && k < 4; n++) begin
            cyc();
            if (cpu_ack) begin
                if (cpu_stall !== 1'b0) stall_bad++;
                ack_n[k] = n; rd_n[k] = cpu_rdata; k++;
                cpu_addr = 32'h80 + 32'(4 * k);
                if (k == 4) cpu_req = 1'b0;
            end else if (cpu_stall !== 1'b1) begin
                stall_bad++;
            end
        end
        cpu_req = 1'b0;
        cyc();
        for (int i = 0; i < 4; i++) begin
            chk("b2b_ack_cycle", 32'(ack_n[i]), 32'(2 + 3 * i));
            chk("b2b_rdata", rd_n[i], 32'h11111111 * 32'(i + 1));
        end
        chk("b2b_stall", 32'(stall_bad), 32'd0);

        // randomized traffic with occasional resets
        for (int i = 0; i < 1200; i++) begin
            cyc();
            if (cpu_req) begin
                if (cpu_ack) begin
                    if ($urandom_range(1) == 1) new_cpu(); else cpu_req = 1'b0;
                end
            end else if ($urandom_range(2) == 0) begin
                new_cpu();
            end
            if (dbg_req) begin
                if (dbg_ack) begin
                    if ($urandom_range(3) == 0) new_dbg(); else dbg_req = 1'b0;
                end
            end else if ($urandom_range(4) == 0) begin
                new_dbg();
            end
            if (rst) rst = 1'b0;
            else if ($urandom_range(199) == 0) rst = 1'b1;
        end
        rst = 1'b0; cpu_req = 1'b0; dbg_req = 1'b0;
        for (int i = 0; i < 6; i++) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
